// File: rtl/twiddle_gen_if.sv
// Twiddle generator request/stream interface.
// The slave modport is the generator side; master is the stage controller / consumer.
interface twiddle_gen_if #(
  parameter int totalbits = 30
);
  logic                        start;
  logic [2:0]                  stage;
  logic                        out_ready;
  logic                        out_valid;
  logic signed [totalbits-1:0] realout;
  logic signed [totalbits-1:0] imagout;
  logic [6:0]                  kexp;
  logic                        last;
  logic                        busy;

  modport master (
    output start, stage, out_ready,
    input  out_valid, realout, imagout, kexp, last, busy
  );

  modport slave (
    input  start, stage, out_ready,
    output out_valid, realout, imagout, kexp, last, busy
  );
endinterface

// File: rtl/twiddle_gen.sv
// Radix-2 DIT twiddle sequencer for a 256-point FFT.
// One accepted start streams 128 twiddles W^k = cos(2*pi*k/256) - j*sin(2*pi*k/256)
// for butterflies b = 0..127 of the latched stage. Only a quarter-wave cosine
// table (65 entries) is stored; the rest comes from quadrant symmetry.
module twiddle_gen #(
  parameter int totalbits = 30,
  parameter int fracbits  = 28
) (
  input  logic          clk,
  input  logic          rst_n,
  twiddle_gen_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  // Table entry m = round(cos(2*pi*m/256) * 2^fracbits), folded at elaboration.
  function automatic logic signed [totalbits-1:0] cos_q(input int m);
    real r;
    r = $cos(6.283185307179586 * real'(m) / 256.0) * (2.0 ** fracbits);
    return totalbits'(longint'(r));
  endfunction

  logic signed [totalbits-1:0] ctab [0:64];

  for (genvar m = 0; m <= 64; m++) begin : g_tab
    localparam logic signed [totalbits-1:0] CV = cos_q(m);
    assign ctab[m] = CV;
  end

  state_t                      state_q, state_d;
  logic                        ov_q, last_q;
  logic [6:0]                  cnt_q, k_q;
  logic [2:0]                  stage_q;
  logic signed [totalbits-1:0] re_q, im_q;

  logic                        acc, fin, load, xfer;
  logic [2:0]                  sel_stage;
  logic [6:0]                  sel_b, mask, k, kp;
  logic signed [totalbits-1:0] re_d, im_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus accept / finish / load strobes
  always_comb begin
    state_d = state_q;
    acc     = 1'b0;
    fin     = 1'b0;
    load    = 1'b0;
    xfer    = ov_q & bus.out_ready;
    case (state_q)
      IDLE: if (bus.start) begin
        acc     = 1'b1;
        load    = 1'b1;
        state_d = RUN;
      end
      RUN: if (xfer && last_q) begin
        fin     = 1'b1;
        state_d = IDLE;
      end else if (xfer || !ov_q) begin
        load    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Exponent of the twiddle to load next and its quadrant-folded table lookup
  always_comb begin
    sel_stage = acc ? bus.stage : stage_q;
    sel_b     = acc ? 7'd0 : (ov_q ? cnt_q + 7'd1 : cnt_q);
    mask      = 7'((8'd1 << sel_stage) - 8'd1);
    k         = (sel_b & mask) << (3'd7 - sel_stage);
    kp        = {1'b0, k[5:0]};
    if (!k[6]) begin
      re_d = ctab[k];
      im_d = -ctab[7'd64 - k];
    end else begin
      re_d = -ctab[7'd64 - kp];
      im_d = -ctab[kp];
    end
  end

  // Output register: load on accept/transfer, hold while stalled, clear after last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_q    <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      stage_q <= '0;
      k_q     <= '0;
      re_q    <= '0;
      im_q    <= '0;
    end else if (fin) begin
      ov_q    <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (load) begin
      ov_q    <= 1'b1;
      last_q  <= (sel_b == 7'd127);
      cnt_q   <= sel_b;
      stage_q <= sel_stage;
      k_q     <= k;
      re_q    <= re_d;
      im_q    <= im_d;
    end
  end

  assign bus.out_valid = ov_q;
  assign bus.last      = last_q;
  assign bus.kexp      = k_q;
  assign bus.realout   = re_q;
  assign bus.imagout   = im_q;
  assign bus.busy      = (state_q == RUN);

endmodule
